// File: rtl/sha3_avmm_pkg.sv
// Shared types and sizing helpers for the SHA-3 Avalon-MM arbiter slice.
package sha3_avmm_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  // Counter only needs to reach timeout-1.
  function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
    return (timeout < 3) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/sha3_rr_pick.sv
// Combinational two-way round-robin picker with lock-owner restriction.
module sha3_rr_pick
  import sha3_avmm_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_grant,
  input  logic       locked,
  input  req_idx_t   owner,
  output logic       gnt_valid,
  output req_idx_t   gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ~last_grant;
    if (locked) begin
      gnt_valid = req[owner];
      gnt_idx   = owner;
    end else if (&req) begin
      gnt_valid = 1'b1;
      gnt_idx   = ~last_grant;
    end else if (req[0]) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b0;
    end else if (req[1]) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b1;
    end
  end

endmodule

// File: rtl/sha3_avmm_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the SHA-3 wrapper slave,
// one transfer in flight, round-robin with optional per-requester lock.
module sha3_avmm_arbiter
  import sha3_avmm_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_r0_address,
  input  logic              avs_r0_read,
  input  logic              avs_r0_write,
  input  logic [DATA_W-1:0] avs_r0_writedata,
  input  logic              avs_r0_lock,
  output logic [DATA_W-1:0] avs_r0_readdata,
  output logic              avs_r0_waitrequest,
  input  logic [ADDR_W-1:0] avs_r1_address,
  input  logic              avs_r1_read,
  input  logic              avs_r1_write,
  input  logic [DATA_W-1:0] avs_r1_writedata,
  input  logic              avs_r1_lock,
  output logic [DATA_W-1:0] avs_r1_readdata,
  output logic              avs_r1_waitrequest,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              lock_timeout
);

  localparam int unsigned CNT_W = tmo_cnt_w(LOCK_TIMEOUT);

  arb_state_t        state;
  req_idx_t          grant;
  req_idx_t          last_grant;
  req_idx_t          owner;
  logic              locked;
  logic [CNT_W-1:0]  tmo_cnt;

  logic [1:0]        req;
  logic              gnt_valid;
  req_idx_t          gnt_idx;
  logic              sel_rd;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              resp_lock;
  logic              tmo_run;
  logic              tmo_hit;

  assign req = {avs_r1_read | avs_r1_write, avs_r0_read | avs_r0_write};

  sha3_rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .locked     (locked),
    .owner      (owner),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // Winner's command; a simultaneous read+write is issued as a write.
  always_comb begin
    sel_wr    = avs_r0_write;
    sel_rd    = avs_r0_read & ~avs_r0_write;
    sel_addr  = avs_r0_address;
    sel_wdata = avs_r0_writedata;
    if (gnt_idx) begin
      sel_wr    = avs_r1_write;
      sel_rd    = avs_r1_read & ~avs_r1_write;
      sel_addr  = avs_r1_address;
      sel_wdata = avs_r1_writedata;
    end
  end

  assign resp_lock = grant ? avs_r1_lock : avs_r0_lock;
  assign tmo_run   = (state == ST_IDLE) && locked && !req[owner];
  assign tmo_hit   = tmo_run && (tmo_cnt == CNT_W'(LOCK_TIMEOUT - 1));

  assign avs_r0_waitrequest = !((state == ST_RESP) && (grant == 1'b0));
  assign avs_r1_waitrequest = !((state == ST_RESP) && (grant == 1'b1));

  // Lock timeout shares this block with the FSM since both update 'locked'.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      grant           <= 1'b0;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      locked          <= 1'b0;
      tmo_cnt         <= '0;
      lock_timeout    <= 1'b0;
      avm_address     <= '0;
      avm_read        <= 1'b0;
      avm_write       <= 1'b0;
      avm_writedata   <= '0;
      avs_r0_readdata <= '0;
      avs_r1_readdata <= '0;
    end else begin
      lock_timeout <= tmo_hit;
      if (!tmo_run || tmo_hit) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (tmo_hit) locked <= 1'b0;
          if (gnt_valid) begin
            grant         <= gnt_idx;
            avm_address   <= sel_addr;
            avm_writedata <= sel_wdata;
            avm_read      <= sel_rd;
            avm_write     <= sel_wr;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!avm_waitrequest) begin
            if (avm_read) begin
              if (grant) avs_r1_readdata <= avm_readdata;
              else       avs_r0_readdata <= avm_readdata;
            end
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant <= grant;
          locked     <= resp_lock;
          if (resp_lock) owner <= grant;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_avmm_arbiter.sv
// Scoreboard bench for sha3_avmm_arbiter: slave model plus per-requester
// expected-response queues checked by a negedge monitor.
module tb_sha3_avmm_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LT = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] avs_r0_address, avs_r1_address, avm_address;
  logic          avs_r0_read, avs_r0_write, avs_r0_lock, avs_r0_waitrequest;
  logic          avs_r1_read, avs_r1_write, avs_r1_lock, avs_r1_waitrequest;
  logic [DW-1:0] avs_r0_writedata, avs_r1_writedata, avs_r0_readdata, avs_r1_readdata;
  logic          avm_read, avm_write, avm_waitrequest, lock_timeout;
  logic [DW-1:0] avm_writedata, avm_readdata;

  always #5 clk = ~clk;

  sha3_avmm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_r0_address(avs_r0_address), .avs_r0_read(avs_r0_read), .avs_r0_write(avs_r0_write),
    .avs_r0_writedata(avs_r0_writedata), .avs_r0_lock(avs_r0_lock),
    .avs_r0_readdata(avs_r0_readdata), .avs_r0_waitrequest(avs_r0_waitrequest),
    .avs_r1_address(avs_r1_address), .avs_r1_read(avs_r1_read), .avs_r1_write(avs_r1_write),
    .avs_r1_writedata(avs_r1_writedata), .avs_r1_lock(avs_r1_lock),
    .avs_r1_readdata(avs_r1_readdata), .avs_r1_waitrequest(avs_r1_waitrequest),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .lock_timeout(lock_timeout)
  );

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  int          order[$];
  int          resp_cyc[$];
  int          tmo_cyc[$];
  logic [31:0] ref_mem [int];
  logic [31:0] slv_mem [int];
  logic [31:0] last_rd [2];

  // slave model state
  int          stall_fix = 0;
  bit          stall_rand = 0;
  bit          slv_active = 0;
  int          slv_wait, slv_stalls, slv_start_cyc, slv_acc_cyc;
  int          slv_xfers = 0;
  logic [7:0]  slv_addr;
  logic [31:0] slv_data;
  logic [1:0]  slv_cmd;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return {16'hA5A5, 8'h00, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input int n, input logic [31:0] rd);
    exp_t e;
    checks++;
    if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL r%0d_spurious_resp: response with nothing outstanding (readdata %h), required none", n, rd);
    end else begin
      if (n == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      if (e.is_rd) begin
        chk($sformatf("r%0d_readdata", n), rd, e.data);
        last_rd[n] = e.data;
      end else begin
        chk($sformatf("r%0d_readdata_hold", n), rd, last_rd[n]);
      end
    end
    order.push_back(n);
    resp_cyc.push_back(cyc);
  endtask

  // Slave model and response monitor, both sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      slv_active      = 0;
      avm_waitrequest = 1'b1;
      last_rd[0]      = '0;
      last_rd[1]      = '0;
    end else begin
      if (avm_read || avm_write) begin
        if (!slv_active) begin
          slv_active    = 1;
          slv_addr      = avm_address;
          slv_data      = avm_writedata;
          slv_cmd       = {avm_read, avm_write};
          slv_wait      = stall_rand ? int'($urandom_range(3, 0)) : stall_fix;
          slv_stalls    = 0;
          slv_start_cyc = cyc;
        end else begin
          chk("avm_addr_stable", 32'(avm_address), 32'(slv_addr));
          chk("avm_wdata_stable", avm_writedata, slv_data);
          chk("avm_cmd_stable", 32'({avm_read, avm_write}), 32'(slv_cmd));
        end
        if (slv_wait > 0) begin
          avm_waitrequest = 1'b1;
          avm_readdata    = $urandom;
          slv_wait--;
          slv_stalls++;
        end else begin
          avm_waitrequest = 1'b0;
          if (slv_cmd[1]) avm_readdata = slv_mem.exists(int'(slv_addr)) ? slv_mem[int'(slv_addr)] : init_val(slv_addr);
          else            slv_mem[int'(slv_addr)] = slv_data;
          slv_acc_cyc = cyc;
          slv_xfers++;
        end
      end else begin
        slv_active      = 0;
        avm_waitrequest = 1'b1;
        avm_readdata    = $urandom;
      end
      if (!avs_r0_waitrequest) check_resp(0, avs_r0_readdata);
      if (!avs_r1_waitrequest) check_resp(1, avs_r1_readdata);
      if (lock_timeout) tmo_cyc.push_back(cyc);
    end
  end

  task automatic drive(input int n, input logic rd, input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic lk);
    if (n == 0) begin
      avs_r0_read = rd; avs_r0_write = wr; avs_r0_address = a; avs_r0_writedata = d; avs_r0_lock = lk;
    end else begin
      avs_r1_read = rd; avs_r1_write = wr; avs_r1_address = a; avs_r1_writedata = d; avs_r1_lock = lk;
    end
  endtask

  function automatic logic wreq(input int n);
    return (n == 0) ? avs_r0_waitrequest : avs_r1_waitrequest;
  endfunction

  // kind: 0 read, 1 write, 2 read+write (must act as a write)
  task automatic expect_push(input int n, input int kind, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.is_rd = (kind == 0);
    e.data  = (kind == 0) ? (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a)) : 32'h0;
    if (kind != 0) ref_mem[int'(a)] = d;
    if (n == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic txn(input int n, input int kind, input logic [7:0] a, input logic [31:0] d, input logic lk);
    int k;
    expect_push(n, kind, a, d);
    drive(n, kind != 1, kind != 0, a, d, lk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (wreq(n) && k < 200);
    checks++;
    if (wreq(n)) begin
      errors++;
      $display("FAIL r%0d_grant_wait: waitrequest 1 after %0d cycles, required 0", n, k);
    end
    @(posedge clk);
    #1;
    drive(n, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    int n0, t0, x0, first, k;
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r0_waitrequest", 32'(avs_r0_waitrequest), 32'd1);
    chk("rst_r1_waitrequest", 32'(avs_r1_waitrequest), 32'd1);
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_avm_address", 32'(avm_address), 32'd0);
    chk("rst_avm_writedata", avm_writedata, 32'd0);
    chk("rst_r0_readdata", avs_r0_readdata, 32'd0);
    chk("rst_r1_readdata", avs_r1_readdata, 32'd0);
    chk("rst_lock_timeout", 32'(lock_timeout), 32'd0);
    reset_n = 1'b1;
    step();

    // first write: strobe after edge 1, response after edge 2, done at edge 3
    expect_push(0, 1, 8'h10, 32'hDEADBEEF);
    drive(0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
    #1 chk("lat_no_early_strobe", 32'(avm_write), 32'd0);
    step();
    chk("lat_e1_avm_write", 32'(avm_write), 32'd1);
    chk("lat_e1_avm_read", 32'(avm_read), 32'd0);
    chk("lat_e1_avm_address", 32'(avm_address), 32'h10);
    chk("lat_e1_avm_writedata", avm_writedata, 32'hDEADBEEF);
    chk("lat_e1_r0_waitrequest", 32'(avs_r0_waitrequest), 32'd1);
    step();
    chk("lat_e2_r0_waitrequest", 32'(avs_r0_waitrequest), 32'd0);
    chk("lat_e2_avm_write", 32'(avm_write), 32'd0);
    step();
    chk("lat_e3_r0_waitrequest", 32'(avs_r0_waitrequest), 32'd1);
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0);

    // read+write together behaves as a write
    txn(1, 2, 8'h90, 32'hCAFEF00D, 1'b0);
    txn(1, 0, 8'h90, 32'h0, 1'b0);

    // contention: round-robin order
    txn(0, 1, 8'h20, 32'h11111111, 1'b0);
    txn(1, 1, 8'h21, 32'h22222222, 1'b0);
    n0 = order.size();
    fork
      txn(0, 0, 8'h20, 32'h0, 1'b0);
      txn(1, 0, 8'h21, 32'h0, 1'b0);
    join
    chk("rr1_first", 32'(order[n0]), 32'd0);
    chk("rr1_second", 32'(order[n0+1]), 32'd1);
    txn(0, 1, 8'h22, 32'h33333333, 1'b0);
    n0 = order.size();
    fork
      txn(0, 0, 8'h20, 32'h0, 1'b0);
      txn(1, 0, 8'h21, 32'h0, 1'b0);
    join
    chk("rr2_first", 32'(order[n0]), 32'd1);
    chk("rr2_second", 32'(order[n0+1]), 32'd0);

    // slave stall of 5 cycles on an r1 read
    stall_fix = 5;
    txn(1, 0, 8'h21, 32'h0, 1'b0);
    stall_fix = 0;
    chk("stall_cycles", 32'(slv_stalls), 32'd5);
    chk("stall_resp_cycle", 32'(resp_cyc[$]), 32'(slv_acc_cyc + 1));

    // a request withdrawn before grant is never issued
    stall_fix = 4;
    x0 = slv_xfers;
    fork
      txn(0, 1, 8'h30, 32'h0BADCAFE, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 drive(1, 1'b1, 1'b0, 8'h31, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
      end
    join
    stall_fix = 0;
    repeat (4) step();
    chk("withdrawn_not_issued", 32'(slv_xfers - x0), 32'd1);

    // lock held over 4 writes while r1 waits
    n0 = order.size();
    fork
      begin
        txn(0, 1, 8'h40, 32'h40404040, 1'b1);
        txn(0, 1, 8'h41, 32'h41414141, 1'b1);
        txn(0, 1, 8'h42, 32'h42424242, 1'b1);
        txn(0, 1, 8'h43, 32'h43434343, 1'b0);
      end
      begin
        @(posedge clk);
        #1 txn(1, 0, 8'h21, 32'h0, 1'b0);
      end
    join
    for (int i = 0; i < 5; i++)
      chk($sformatf("lock_order_%0d", i), 32'(order[n0+i]), (i < 4) ? 32'd0 : 32'd1);

    // lock timeout: owner goes silent, r1 waits
    n0 = order.size();
    t0 = tmo_cyc.size();
    fork
      txn(0, 1, 8'h44, 32'h44444444, 1'b1);
      begin
        @(posedge clk);
        #1 txn(1, 0, 8'h20, 32'h0, 1'b0);
      end
    join
    chk("tmo_order_owner", 32'(order[n0]), 32'd0);
    chk("tmo_order_other", 32'(order[n0+1]), 32'd1);
    chk("tmo_pulse_count", 32'(tmo_cyc.size() - t0), 32'd1);
    if (tmo_cyc.size() > t0) begin
      chk("tmo_pulse_delay", 32'(tmo_cyc[t0] - resp_cyc[n0]), 32'(LT + 1));
      chk("tmo_next_grant", 32'(slv_start_cyc), 32'(tmo_cyc[t0] + 1));
    end

    // random back-to-back traffic must alternate strictly
    stall_rand = 1;
    first = 1 - order[$];
    n0 = order.size();
    fork
      for (int i = 0; i < 12; i++)
        txn(0, int'($urandom_range(2, 0)), 8'($urandom_range(127, 0)), $urandom, 1'b0);
      for (int i = 0; i < 12; i++)
        txn(1, int'($urandom_range(2, 0)), 8'(8'h80 | 8'($urandom_range(127, 0))), $urandom, 1'b0);
    join
    for (int i = 0; i < 24; i++)
      chk($sformatf("alt_order_%0d", i), 32'(order[n0+i]), 32'((first + i) % 2));

    // random traffic with gaps and occasional locks
    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(3, 0)) @(posedge clk);
        #1 txn(0, int'($urandom_range(2, 0)), 8'($urandom_range(127, 0)), $urandom,
               1'($urandom_range(3, 0) == 0));
      end
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(3, 0)) @(posedge clk);
        #1 txn(1, int'($urandom_range(2, 0)), 8'(8'h80 | 8'($urandom_range(127, 0))), $urandom,
               1'($urandom_range(3, 0) == 0));
      end
    join
    stall_rand = 0;
    repeat (LT + 4) step();

    // asynchronous reset during ISSUE aborts the transfer
    stall_fix = 20;
    drive(0, 1'b0, 1'b1, 8'h50, 32'h12345678, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!avm_write && k < 10);
    chk("abort_strobe_up", 32'(avm_write), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_avm_write_async", 32'(avm_write), 32'd0);
    chk("abort_avm_read_async", 32'(avm_read), 32'd0);
    chk("abort_r0_waitrequest", 32'(avs_r0_waitrequest), 32'd1);
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    stall_fix = 0;
    repeat (10) step();
    txn(1, 0, 8'h21, 32'h0, 1'b0);
    repeat (3) step();

    chk("r0_outstanding", 32'(q0.size()), 32'd0);
    chk("r1_outstanding", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha3_avmm_arbiter.md
Name: sha3_avmm_arbiter

Overview:
- Two-requester Avalon-MM arbiter that shares one avalon_sha3_wrapper slave (word-addressed, 8-bit address, 32-bit data, waitrequest flow control) between two masters, e.g. CPU and DMA.
- Serialises single transactions with round-robin fairness.
- Supports a per-requester lock, so one master can own the core for a whole absorb/squeeze job.
- Sits between the interconnect and u_sha3; the master-side port connects directly to the wrapper's avs_s0_* pins.

Parameters:
- ADDR_W, 8, word address width on all ports.
- DATA_W, 32, data width on all ports.
- LOCK_TIMEOUT, 1024, idle cycles after which an unused lock is forcibly released (>=2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avs_r0_address  in  ADDR_W  requester 0 word address.
- avs_r0_read  in  1  requester 0 read strobe.
- avs_r0_write  in  1  requester 0 write strobe.
- avs_r0_writedata  in  DATA_W  requester 0 write data.
- avs_r0_lock  in  1  requester 0 requests ownership beyond the current transfer.
- avs_r0_readdata  out  DATA_W  requester 0 read data.
- avs_r0_waitrequest  out  1  requester 0 stall.
- avs_r1_*  same set for requester 1.
- avm_address  out  ADDR_W  to u_sha3 avs_s0_address.
- avm_read  out  1  to u_sha3 avs_s0_read.
- avm_write  out  1  to u_sha3 avs_s0_write.
- avm_writedata  out  DATA_W  to u_sha3 avs_s0_writedata.
- avm_readdata  in  DATA_W  from u_sha3.
- avm_waitrequest  in  1  from u_sha3.
- lock_timeout  out  1  one-cycle pulse when a lock is force-released.

Behaviour:
- Reset values: state IDLE; avm_read=0, avm_write=0, avm_address=0, avm_writedata=0; both avs_rN_readdata=0; both avs_rN_waitrequest=1; locked=0; last_grant=1 (requester 0 wins first); timeout counter 0; lock_timeout=0.
- Reset mid-transfer drops avm_read/avm_write immediately and discards the transfer; no response is given.
- A request is reqN = avs_rN_read | avs_rN_write. If read and write are both high, write wins.
- FSM (one state register):
  - IDLE
    - Eligible set: if locked, only the owner; else both.
    - Single eligible request: grant it.
    - Both eligible and requesting: grant ~last_grant.
    - On grant: latch address, writedata and read/write of the winner into avm_* registers; go ISSUE.
  - ISSUE
    - avm_read/avm_write held high with stable address/data.
    - Stay while avm_waitrequest=1; no timeout.
    - At the first edge with avm_waitrequest=0: capture avm_readdata if read; clear avm_read/avm_write; go RESP.
  - RESP
    - avs_rG_waitrequest=0 for exactly this cycle; avs_rG_readdata holds the captured data (stable until the next read response to that requester).
    - last_grant<=G.
    - If avs_rG_lock=1: locked<=1, owner<=G; else locked<=0.
    - Go IDLE.
- avs_rN_waitrequest = ~(state==RESP && grant==N), combinational from registers only.
- Latency: request seen in IDLE at edge 0 -> avm strobe at edge 1 -> with a zero-wait slave, RESP at edge 2 -> requester completes at edge 3. Minimum 3 cycles per transfer; one transfer in flight at a time.
- Lock timeout:
  - Counter runs while state==IDLE, locked=1 and the owner is not requesting; it clears otherwise.
  - On reaching LOCK_TIMEOUT-1: locked<=0, lock_timeout pulses 1 cycle, counter clears. The other requester may be granted the following IDLE cycle.
- A non-owner requesting while locked stalls (waitrequest=1) indefinitely until release or timeout.
- A requester that drops its strobe before grant is simply not served; no error.

Decomposition:
- Package sha3_avmm_pkg: state encoding (IDLE/ISSUE/RESP), ADDR_W/DATA_W defaults, requester index type, clog2-based timeout counter width.
- Sub-module sha3_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, locked, owner.
  - Outputs: gnt_valid, gnt_idx.
  - Reused by future N-requester variants.

Test Plan:
- Reset: hold reset_n=0 -> both waitrequest=1, avm_read=avm_write=0. Release; r0 writes 0xDEADBEEF to addr 0x10 -> avm_write with address 0x10, data 0xDEADBEEF at edge 1; r0 waitrequest low at edge 2.
- Contention: r0 and r1 read addr 0x20 and 0x21 in the same cycle, slave readdata 0x11111111 then 0x22222222 -> r0 served first with 0x11111111, then r1 with 0x22222222. Repeat -> r1 served first.
- Slave stall: avm_waitrequest high for 5 cycles on an r1 read -> avm_read and address stable for all 5; r1 waitrequest low exactly 1 cycle after the stall ends, readdata correct.
- Lock: r0 sets lock and issues 4 writes while r1 requests continuously -> all 4 r0 writes precede any r1 grant. r0 drops lock on the 4th -> r1 granted next.
- Lock timeout with LOCK_TIMEOUT=16: r0 locks, then goes silent while r1 requests -> lock_timeout pulses exactly 16 idle cycles later; r1 granted the next cycle.
- Async reset asserted during ISSUE -> avm_write falls without a clock edge; after release, no RESP is produced for the aborted transfer.
